clk_rst_seq: RTL and testbench

Clock/reset sequencer between the DCM clock generator and the rest of the LED controller, running on `mclk`.
- Qualifies the DCM lock and releases the system reset `rstb` only after lock has been stable for a set time.
- Replaces ripple-divided key clocks with single-cycle clock enables.
- Performs glitch-free `clkdot` source switching: gates the clock, changes the mux select, then ungates.

---
 rtl/clk_pkg.sv | 28 ++
 rtl/sync2.sv | 22 ++
 rtl/clk_rst_seq.sv | 145 ++++++++++++++
 tb/tb_clk_rst_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared types and defaults for the clock/reset sequencer.
// Holds the FSM state enum and clkdot source encodings.
package clk_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_GATE,
    ST_SEL,
    ST_UNGATE
  } state_t;

  localparam int DEF_LOCK_CNT      = 16;
  localparam int DEF_GATE_CNT      = 4;
  localparam int DEF_SET_DIV_LOG2  = 7;
  localparam int DEF_SCAN_DIV_LOG2 = 11;

  localparam logic CLKDOT_PRI = 1'b0;
  localparam logic CLKDOT_DIV = 1'b1;

  // States in which the system is out of reset
  function automatic logic is_live(input state_t s);
    return (s == ST_RUN) || (s == ST_GATE) ||
           (s == ST_SEL) || (s == ST_UNGATE);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Reusable for any slow async level signal.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_rst_seq.sv
// Clock/reset sequencer: DCM lock qualification, key clock
// enables and glitch-free clkdot source switching on mclk.
module clk_rst_seq
  import clk_pkg::*;
#(
  parameter int LOCK_CNT      = DEF_LOCK_CNT,
  parameter int GATE_CNT      = DEF_GATE_CNT,
  parameter int SET_DIV_LOG2  = DEF_SET_DIV_LOG2,
  parameter int SCAN_DIV_LOG2 = DEF_SCAN_DIV_LOG2
) (
  input  logic mclk,
  input  logic RESET,
  input  logic dcm_lock,
  input  logic clk_set,
  output logic rstb,
  output logic clkdot_sel,
  output logic clkdot_en,
  output logic key_scan_en,
  output logic key_set_en,
  output logic switch_busy,
  output logic lock_lost
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int GW = $clog2(GATE_CNT + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CNT - 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CNT - 1);

  logic lock_s;

  state_t state_q, state_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [SCAN_DIV_LOG2-1:0] pre_q;

  logic rstb_d, en_d, busy_d, sel_d, lost_d;

  sync2 u_lock_sync (
    .clk (mclk),
    .rst (RESET),
    .d   (dcm_lock),
    .q   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    gcnt_d  = gcnt_q;
    rstb_d  = rstb;
    en_d    = clkdot_en;
    busy_d  = switch_busy;
    sel_d   = clkdot_sel;
    lost_d  = lock_lost;
    // Lock loss abandons any switch; clkdot_sel is left as is
    if (is_live(state_q) && !lock_s) begin
      state_d = ST_WAIT_LOCK;
      rstb_d  = 1'b0;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      lost_d  = 1'b1;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          rstb_d = 1'b0;
          en_d   = 1'b0;
          if (lock_s) begin
            state_d = ST_STABLE;
            lcnt_d  = '0;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (lcnt_q == LOCK_LAST) begin
            state_d = ST_RUN;
            rstb_d  = 1'b1;
            en_d    = 1'b1;
          end else begin
            lcnt_d = lcnt_q + LW'(1);
          end
        end
        ST_RUN: begin
          if (clk_set != clkdot_sel) begin
            state_d = ST_GATE;
            en_d    = 1'b0;
            busy_d  = 1'b1;
            gcnt_d  = '0;
          end
        end
        ST_GATE: begin
          if (gcnt_q == GATE_LAST) begin
            state_d = ST_SEL;
          end else begin
            gcnt_d = gcnt_q + GW'(1);
          end
        end
        // Target is fixed at switch start; later changes re-switch
        ST_SEL: begin
          sel_d   = ~clkdot_sel;
          state_d = ST_UNGATE;
          gcnt_d  = '0;
        end
        ST_UNGATE: begin
          if (gcnt_q == GATE_LAST) begin
            state_d = ST_RUN;
            en_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            gcnt_d = gcnt_q + GW'(1);
          end
        end
        default: state_d = ST_WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (RESET) begin
      state_q     <= ST_WAIT_LOCK;
      lcnt_q      <= '0;
      gcnt_q      <= '0;
      pre_q       <= '0;
      rstb        <= 1'b0;
      clkdot_sel  <= CLKDOT_PRI;
      clkdot_en   <= 1'b0;
      switch_busy <= 1'b0;
      lock_lost   <= 1'b0;
      key_set_en  <= 1'b0;
      key_scan_en <= 1'b0;
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      gcnt_q      <= gcnt_d;
      rstb        <= rstb_d;
      clkdot_sel  <= sel_d;
      clkdot_en   <= en_d;
      switch_busy <= busy_d;
      lock_lost   <= lost_d;
      pre_q       <= is_live(state_q) ? pre_q + 1'b1 : '0;
      key_set_en  <= &pre_q[SET_DIV_LOG2-1:0];
      key_scan_en <= &pre_q;
    end
  end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed self-checking bench for clk_rst_seq.
// Inputs change #1 after posedge; outputs sampled there too.
module tb_clk_rst_seq;

  logic mclk = 1'b0;
  logic RESET = 1'b1;
  logic dcm_lock = 1'b0;
  logic clk_set = 1'b0;
  logic rstb, clkdot_sel, clkdot_en;
  logic key_scan_en, key_set_en;
  logic switch_busy, lock_lost;

  int checks = 0;
  int errors = 0;

  always #5 mclk = ~mclk;

  clk_rst_seq dut (
    .mclk        (mclk),
    .RESET       (RESET),
    .dcm_lock    (dcm_lock),
    .clk_set     (clk_set),
    .rstb        (rstb),
    .clkdot_sel  (clkdot_sel),
    .clkdot_en   (clkdot_en),
    .key_scan_en (key_scan_en),
    .key_set_en  (key_set_en),
    .switch_busy (switch_busy),
    .lock_lost   (lock_lost)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic reset_dut();
    RESET = 1'b1;
    dcm_lock = 1'b0;
    clk_set = 1'b0;
    tick(3);
    RESET = 1'b0;
  endtask

  task automatic bring_up();
    reset_dut();
    dcm_lock = 1'b1;
    tick(19);
  endtask

  task automatic test_reset();
    logic [6:0] v;
    RESET = 1'b1;
    dcm_lock = 1'b1;
    clk_set = 1'b1;
    tick(5);
    v = {rstb, clkdot_sel, clkdot_en, key_scan_en,
         key_set_en, switch_busy, lock_lost};
    checks++;
    if (v !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", v, 7'b0);
    end
    RESET = 1'b0;
    dcm_lock = 1'b0;
    clk_set = 1'b0;
    tick(4);
    checks++;
    if (rstb !== 1'b0) begin
      errors++;
      $display("FAIL idle_rstb got=%b exp=0", rstb);
    end
  endtask

  task automatic test_lockup();
    dcm_lock = 1'b1;
    tick(18);
    checks++;
    if (rstb !== 1'b0) begin
      errors++;
      $display("FAIL lock_early got=%b exp=0", rstb);
    end
    tick(1);
    checks++;
    if ({rstb, clkdot_en, switch_busy, clkdot_sel} !== 4'b1100) begin
      errors++;
      $display("FAIL lock_release got=%b exp=1100",
               {rstb, clkdot_en, switch_busy, clkdot_sel});
    end
  endtask

  task automatic test_glitchy_lock();
    logic early;
    reset_dut();
    dcm_lock = 1'b1;
    tick(8);
    dcm_lock = 1'b0;
    tick(1);
    dcm_lock = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 18; i++) begin
      tick(1);
      if (rstb !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL glitch_early got=%b exp=0", early);
    end
    tick(1);
    checks++;
    if (rstb !== 1'b1) begin
      errors++;
      $display("FAIL glitch_release got=%b exp=1", rstb);
    end
  endtask

  task automatic test_key_enables();
    int nset, nscan, first_set;
    logic coincide;
    bring_up();
    nset = 0;
    nscan = 0;
    first_set = 0;
    coincide = 1'b0;
    for (int i = 1; i <= 4096; i++) begin
      tick(1);
      if (key_set_en === 1'b1) begin
        nset++;
        if (first_set == 0) first_set = i;
      end
      if (key_scan_en === 1'b1) begin
        nscan++;
        if (nscan == 1) coincide = key_set_en;
      end
    end
    checks++;
    if (nset != 32) begin
      errors++;
      $display("FAIL set_count got=%0d exp=32", nset);
    end
    checks++;
    if (nscan != 2) begin
      errors++;
      $display("FAIL scan_count got=%0d exp=2", nscan);
    end
    checks++;
    if (first_set != 128) begin
      errors++;
      $display("FAIL first_set got=%0d exp=128", first_set);
    end
    checks++;
    if (coincide !== 1'b1) begin
      errors++;
      $display("FAIL scan_with_set got=%b exp=1", coincide);
    end
  endtask

  task automatic test_switch();
    int en_low, busy_n, sel_at, rise_at;
    logic bad, prev_sel;
    bring_up();
    clk_set = 1'b1;
    en_low = 0;
    busy_n = 0;
    sel_at = 0;
    rise_at = 0;
    bad = 1'b0;
    prev_sel = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick(1);
      if (clkdot_en === 1'b0) en_low++;
      if (switch_busy === 1'b1) busy_n++;
      if (clkdot_sel !== prev_sel) begin
        sel_at = i;
        if (clkdot_en !== 1'b0) bad = 1'b1;
      end
      prev_sel = clkdot_sel;
      if (clkdot_en === 1'b1 && rise_at == 0) rise_at = i;
    end
    checks++;
    if (en_low != 9) begin
      errors++;
      $display("FAIL sw_en_low got=%0d exp=9", en_low);
    end
    checks++;
    if (busy_n != 9) begin
      errors++;
      $display("FAIL sw_busy got=%0d exp=9", busy_n);
    end
    checks++;
    if (sel_at != 6) begin
      errors++;
      $display("FAIL sw_sel_at got=%0d exp=6", sel_at);
    end
    checks++;
    if (rise_at != 10) begin
      errors++;
      $display("FAIL sw_en_rise got=%0d exp=10", rise_at);
    end
    checks++;
    if (bad !== 1'b0 || clkdot_sel !== 1'b1) begin
      errors++;
      $display("FAIL sw_sel_gated got=%b/%b exp=0/1",
               bad, clkdot_sel);
    end
  endtask

  task automatic test_toggle();
    int changes;
    logic bad, prev_sel, prev_en, sel10, en10;
    bring_up();
    clk_set = 1'b1;
    tick(2);
    clk_set = 1'b0;
    changes = 0;
    bad = 1'b0;
    prev_sel = clkdot_sel;
    prev_en = clkdot_en;
    sel10 = 1'b0;
    en10 = 1'b0;
    for (int i = 3; i <= 30; i++) begin
      tick(1);
      if (clkdot_sel !== prev_sel) begin
        changes++;
        if (clkdot_en !== 1'b0 || prev_en !== 1'b0) bad = 1'b1;
      end
      prev_sel = clkdot_sel;
      prev_en = clkdot_en;
      if (i == 10) begin
        sel10 = clkdot_sel;
        en10 = clkdot_en;
      end
    end
    checks++;
    if ({sel10, en10} !== 2'b11) begin
      errors++;
      $display("FAIL tog_first got=%b exp=11", {sel10, en10});
    end
    checks++;
    if (changes != 2) begin
      errors++;
      $display("FAIL tog_changes got=%0d exp=2", changes);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL tog_en_gate got=%b exp=0", bad);
    end
    checks++;
    if ({clkdot_sel, clkdot_en, switch_busy} !== 3'b010) begin
      errors++;
      $display("FAIL tog_final got=%b exp=010",
               {clkdot_sel, clkdot_en, switch_busy});
    end
  endtask

  task automatic test_lock_loss();
    logic en_seen;
    bring_up();
    clk_set = 1'b1;
    tick(5);
    dcm_lock = 1'b0;
    clk_set = 1'b0;
    tick(2);
    checks++;
    if (rstb !== 1'b1) begin
      errors++;
      $display("FAIL loss_early got=%b exp=1", rstb);
    end
    tick(1);
    checks++;
    if ({rstb, lock_lost, clkdot_en, clkdot_sel} !== 4'b0101) begin
      errors++;
      $display("FAIL loss_reset got=%b exp=0101",
               {rstb, lock_lost, clkdot_en, clkdot_sel});
    end
    tick(3);
    dcm_lock = 1'b1;
    en_seen = 1'b0;
    for (int i = 0; i < 18; i++) begin
      tick(1);
      if (clkdot_en !== 1'b0 || rstb !== 1'b0) en_seen = 1'b1;
    end
    checks++;
    if (en_seen !== 1'b0) begin
      errors++;
      $display("FAIL loss_hold got=%b exp=0", en_seen);
    end
    tick(1);
    checks++;
    if ({rstb, clkdot_en, lock_lost, switch_busy} !== 4'b1110) begin
      errors++;
      $display("FAIL relock got=%b exp=1110",
               {rstb, clkdot_en, lock_lost, switch_busy});
    end
    tick(1);
    checks++;
    if ({clkdot_en, switch_busy} !== 2'b01) begin
      errors++;
      $display("FAIL pend_start got=%b exp=01",
               {clkdot_en, switch_busy});
    end
    tick(5);
    checks++;
    if ({clkdot_sel, clkdot_en} !== 2'b00) begin
      errors++;
      $display("FAIL pend_sel got=%b exp=00",
               {clkdot_sel, clkdot_en});
    end
    tick(4);
    checks++;
    if ({clkdot_en, switch_busy, lock_lost} !== 3'b101) begin
      errors++;
      $display("FAIL pend_done got=%b exp=101",
               {clkdot_en, switch_busy, lock_lost});
    end
  endtask

  task automatic test_lost_clear();
    reset_dut();
    checks++;
    if (lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL lost_clear got=%b exp=0", lock_lost);
    end
  endtask

  initial begin
    test_reset();
    test_lockup();
    test_glitchy_lock();
    test_key_enables();
    test_switch();
    test_toggle();
    test_lock_loss();
    test_lost_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
